// File: rtl/lock_code_if.sv
// lock_code_if: keypad-side inputs and status outputs of the code-lock controller.
// The controller connects through the slave modport; the keypad scanner / display
// side (or a testbench) connects through the master modport.
interface lock_code_if #(
    parameter int CODE_LEN = 4
);

    logic [3:0]            i_key_val;
    logic                  i_key_flag;
    logic                  o_unlock;
    logic                  o_err;
    logic                  o_alarm;
    logic                  o_set_mode;
    logic [2:0]            o_digit_cnt;
    logic [CODE_LEN*4-1:0] o_entry;
    logic [2:0]            o_fail_cnt;

    modport master (
        output i_key_val,
        output i_key_flag,
        input  o_unlock,
        input  o_err,
        input  o_alarm,
        input  o_set_mode,
        input  o_digit_cnt,
        input  o_entry,
        input  o_fail_cnt
    );

    modport slave (
        input  i_key_val,
        input  i_key_flag,
        output o_unlock,
        output o_err,
        output o_alarm,
        output o_set_mode,
        output o_digit_cnt,
        output o_entry,
        output o_fail_cnt
    );

endinterface

// File: rtl/lock_code_ctrl.sv
// lock_code_ctrl: password entry and verification controller fed by the 4x4
// keypad scanner. Digits collect into an entry buffer (newest digit in the low
// nibble, unused nibbles 4'hF). The buffer is compared with the stored code.
// Repeated failures cause a timed lockout. While unlocked, the code can be changed.
//
// Optional feature macro: AUTO_RELOCK_EN
//   defined   - OPEN relocks by itself after OPEN_CYCLES cycles; any key
//               committed in OPEN restarts that timer.
//   undefined - OPEN persists until A or D; no OPEN timer logic is built.
module lock_code_ctrl #(
    parameter int                    CODE_LEN     = 4,
    parameter logic [CODE_LEN*4-1:0] DEFAULT_CODE = 16'h1234,
    parameter int                    MAX_FAIL     = 3,
    parameter int                    LOCK_CYCLES  = 500_000_000,
    parameter int                    OPEN_CYCLES  = 250_000_000
) (
    input  logic      i_clk,
    input  logic      i_rst,
    lock_code_if.slave bus
);

    localparam int W         = CODE_LEN * 4;
    localparam int TIMER_MAX = (LOCK_CYCLES > OPEN_CYCLES) ? LOCK_CYCLES : OPEN_CYCLES;
    localparam int TIMER_W   = $clog2(TIMER_MAX + 1);

    localparam logic [W-1:0]       ALL_F      = '1;
    localparam logic [W-1:0]       TOP_F      = ~(ALL_F >> 4);
    localparam logic [2:0]         LEN        = 3'(CODE_LEN);
    localparam logic [2:0]         FAIL_LIMIT = 3'(MAX_FAIL);
    localparam logic [TIMER_W-1:0] LOCK_LAST  = TIMER_W'(LOCK_CYCLES - 1);
`ifdef AUTO_RELOCK_EN
    localparam logic [TIMER_W-1:0] OPEN_LAST  = TIMER_W'(OPEN_CYCLES - 1);
`endif

    typedef enum logic [2:0] {
        S_ENTRY,
        S_CHECK,
        S_OPEN,
        S_LOCKOUT,
        S_SET_NEW
    } state_t;

    state_t             state_q, state_d;
    logic [2:0]         flagSync_q;
    logic               armed_q, armed_d;
    logic [W-1:0]       entryBuf_q, entryBuf_d;
    logic [2:0]         digitCnt_q, digitCnt_d;
    logic [W-1:0]       storedCode_q, storedCode_d;
    logic [2:0]         failCnt_q, failCnt_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic               err_q, err_d;

    logic [3:0]   keyVal;
    logic         keyIsDigit;
    logic         keyEnter;
    logic         keyBack;
    logic         keyClear;
    logic         keyChange;
    logic         keyFall;
    logic         keyRise;
    logic         commit;
    logic         openCommit;
    logic         codeMatch;
    logic [2:0]   failInc;
    logic         editValid;
    logic [W-1:0] editBuf;
    logic [2:0]   editCnt;

    assign keyVal     = bus.i_key_val;
    assign keyIsDigit = (keyVal <= 4'd9);
    assign keyEnter   = (keyVal == 4'hA);
    assign keyBack    = (keyVal == 4'hB);
    assign keyClear   = (keyVal == 4'hC);
    assign keyChange  = (keyVal == 4'hD);

    // Stage 1/2 synchronize the strobe; stage 3 is the previous value for edge detection.
    assign keyFall = flagSync_q[2] & ~flagSync_q[1];
    assign keyRise = ~flagSync_q[2] & flagSync_q[1];

    assign codeMatch = (digitCnt_q == LEN) && (entryBuf_q == storedCode_q);
    assign failInc   = (failCnt_q == 3'd7) ? 3'd7 : failCnt_q + 3'd1;

`ifdef AUTO_RELOCK_EN
    assign openCommit = commit && (timer_q != OPEN_LAST);
`else
    assign openCommit = commit;
`endif

    // Two-flop synchronizer plus history stage on the active-low key strobe (idle high)
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            flagSync_q <= 3'b111;
        end else begin
            flagSync_q <= {flagSync_q[1:0], bus.i_key_flag};
        end
    end

    // Buffer edit shared by ENTRY and SET_NEW: digit append, backspace, clear
    always_comb begin
        editValid = 1'b0;
        editBuf   = entryBuf_q;
        editCnt   = digitCnt_q;
        if (keyIsDigit) begin
            editValid = 1'b1;
            if (digitCnt_q < LEN) begin
                editBuf = (entryBuf_q << 4) | W'(keyVal);
                editCnt = digitCnt_q + 3'd1;
            end
        end else if (keyBack) begin
            editValid = 1'b1;
            if (digitCnt_q != 3'd0) begin
                editBuf = (entryBuf_q >> 4) | TOP_F;
                editCnt = digitCnt_q - 3'd1;
            end
        end else if (keyClear) begin
            editValid = 1'b1;
            editBuf   = ALL_F;
            editCnt   = 3'd0;
        end
    end

    // Key event arming/commit, next state and datapath updates
    always_comb begin
        state_d      = state_q;
        armed_d      = armed_q;
        entryBuf_d   = entryBuf_q;
        digitCnt_d   = digitCnt_q;
        storedCode_d = storedCode_q;
        failCnt_d    = failCnt_q;
        timer_d      = timer_q;
        err_d        = 1'b0;
        commit       = 1'b0;

        if (keyFall) begin
            armed_d = 1'b1;
        end else if (keyRise && armed_q) begin
            armed_d = 1'b0;
            commit  = 1'b1;
        end

        unique case (state_q)
            S_ENTRY: begin
                if (commit) begin
                    if (editValid) begin
                        entryBuf_d = editBuf;
                        digitCnt_d = editCnt;
                    end else if (keyEnter) begin
                        state_d = S_CHECK;
                    end
                end
            end

            S_CHECK: begin
                entryBuf_d = ALL_F;
                digitCnt_d = 3'd0;
                timer_d    = '0;
                if (codeMatch) begin
                    failCnt_d = 3'd0;
                    state_d   = S_OPEN;
                end else begin
                    err_d     = 1'b1;
                    failCnt_d = failInc;
                    if (failInc >= FAIL_LIMIT) begin
                        state_d = S_LOCKOUT;
                    end else begin
                        state_d = S_ENTRY;
                    end
                end
            end

            S_LOCKOUT: begin
                armed_d = 1'b0;
                if (timer_q == LOCK_LAST) begin
                    failCnt_d = 3'd0;
                    timer_d   = '0;
                    state_d   = S_ENTRY;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end

            S_OPEN: begin
`ifdef AUTO_RELOCK_EN
                if (timer_q == OPEN_LAST) begin
                    timer_d = '0;
                    state_d = S_ENTRY;
                end else if (commit) begin
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
`endif
                if (openCommit) begin
                    if (keyEnter) begin
                        state_d = S_ENTRY;
                    end else if (keyChange) begin
                        entryBuf_d = ALL_F;
                        digitCnt_d = 3'd0;
                        state_d    = S_SET_NEW;
                    end
                end
            end

            S_SET_NEW: begin
                if (commit) begin
                    if (editValid) begin
                        entryBuf_d = editBuf;
                        digitCnt_d = editCnt;
                    end else if (keyEnter) begin
                        entryBuf_d = ALL_F;
                        digitCnt_d = 3'd0;
                        if (digitCnt_q == LEN) begin
                            storedCode_d = entryBuf_q;
                            state_d      = S_ENTRY;
                        end else begin
                            err_d = 1'b1;
                        end
                    end else if (keyChange) begin
                        entryBuf_d = ALL_F;
                        digitCnt_d = 3'd0;
                        timer_d    = '0;
                        state_d    = S_OPEN;
                    end
                end
            end

            default: begin
                state_d = S_ENTRY;
            end
        endcase
    end

    // State and datapath registers; reset aborts any state and restores the default code
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q      <= S_ENTRY;
            armed_q      <= 1'b0;
            entryBuf_q   <= ALL_F;
            digitCnt_q   <= 3'd0;
            storedCode_q <= DEFAULT_CODE;
            failCnt_q    <= 3'd0;
            timer_q      <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            armed_q      <= armed_d;
            entryBuf_q   <= entryBuf_d;
            digitCnt_q   <= digitCnt_d;
            storedCode_q <= storedCode_d;
            failCnt_q    <= failCnt_d;
            timer_q      <= timer_d;
            err_q        <= err_d;
        end
    end

    assign bus.o_unlock    = (state_q == S_OPEN);
    assign bus.o_alarm     = (state_q == S_LOCKOUT);
    assign bus.o_set_mode  = (state_q == S_SET_NEW);
    assign bus.o_err       = err_q;
    assign bus.o_digit_cnt = digitCnt_q;
    assign bus.o_entry     = entryBuf_q;
    assign bus.o_fail_cnt  = failCnt_q;

endmodule

// File: tb/tb_lock_code_ctrl.sv
// tb_lock_code_ctrl: directed key sequences against lock_code_ctrl with a
// queue-based reference model compared every cycle, plus literal spot checks.
module tb_lock_code_ctrl;

    localparam int CODE_LEN    = 4;
    localparam int W           = CODE_LEN * 4;
    localparam int MAX_FAIL    = 3;
    localparam int LOCK_CYCLES = 20;
    localparam int OPEN_CYCLES = 10;

    logic clk = 1'b0;
    logic rst;

    int checks = 0;
    int errors = 0;

    lock_code_if #(.CODE_LEN(CODE_LEN)) bus ();

    lock_code_ctrl #(
        .CODE_LEN     (CODE_LEN),
        .DEFAULT_CODE (16'h1234),
        .MAX_FAIL     (MAX_FAIL),
        .LOCK_CYCLES  (LOCK_CYCLES),
        .OPEN_CYCLES  (OPEN_CYCLES)
    ) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    // Free-running clock
    always #5 clk = ~clk;

    // Reference model state
    logic [3:0] mEntry[$];
    logic [3:0] mCode[$];
    string      mMode;
    int         mFail;
    bit         mErr;
    int         mLockLeft;
    int         mOpenLeft;
    bit         mArmed;
    bit         mH1, mH2, mH3;
    bit         mFall, mRise, mCommit;
    logic [3:0] mKey;
    bit         modelReady = 1'b0;

    int errPulses   = 0;
    int alarmCycles = 0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] modelEntryWord();
        logic [W-1:0] w;
        int n;
        w = '1;
        n = mEntry.size();
        for (int i = 0; i < n; i++) begin
            w[4*(n-1-i) +: 4] = mEntry[i];
        end
        return w;
    endfunction

    function automatic bit codesEqual();
        if (mEntry.size() != mCode.size()) return 1'b0;
        for (int i = 0; i < mEntry.size(); i++) begin
            if (mEntry[i] != mCode[i]) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic modelEdit(input logic [3:0] k);
        if (k <= 4'd9) begin
            if (mEntry.size() < CODE_LEN) mEntry.push_back(k);
        end else if (k == 4'hB) begin
            if (mEntry.size() > 0) void'(mEntry.pop_back());
        end else if (k == 4'hC) begin
            mEntry.delete();
        end
    endtask

    // Reference model: one key action per press, applied from the mode rules
    always @(posedge clk) begin
        if (rst) begin
            mEntry.delete();
            mCode      = '{4'h1, 4'h2, 4'h3, 4'h4};
            mMode      = "ENTRY";
            mFail      = 0;
            mErr       = 1'b0;
            mLockLeft  = 0;
            mOpenLeft  = 0;
            mArmed     = 1'b0;
            mH1        = 1'b1;
            mH2        = 1'b1;
            mH3        = 1'b1;
            modelReady = 1'b1;
        end else if (modelReady) begin
            mFall   = mH3 && !mH2;
            mRise   = !mH3 && mH2;
            mCommit = 1'b0;
            if (mFall) mArmed = 1'b1;
            else if (mRise && mArmed) begin
                mArmed  = 1'b0;
                mCommit = 1'b1;
            end
            mH3  = mH2;
            mH2  = mH1;
            mH1  = bus.i_key_flag;
            mKey = bus.i_key_val;
            mErr = 1'b0;
            if (mMode == "ENTRY") begin
                if (mCommit) begin
                    if (mKey == 4'hA) mMode = "CHECK";
                    else modelEdit(mKey);
                end
            end else if (mMode == "CHECK") begin
                if (codesEqual()) begin
                    mFail     = 0;
                    mMode     = "OPEN";
                    mOpenLeft = OPEN_CYCLES;
                end else begin
                    mErr  = 1'b1;
                    mFail = (mFail < 7) ? mFail + 1 : 7;
                    if (mFail >= MAX_FAIL) begin
                        mMode     = "LOCKOUT";
                        mLockLeft = LOCK_CYCLES;
                    end else begin
                        mMode = "ENTRY";
                    end
                end
                mEntry.delete();
            end else if (mMode == "LOCKOUT") begin
                mArmed = 1'b0;
                mLockLeft--;
                if (mLockLeft == 0) begin
                    mFail = 0;
                    mMode = "ENTRY";
                end
            end else if (mMode == "OPEN") begin
`ifdef AUTO_RELOCK_EN
                if (mOpenLeft == 1) begin
                    mMode   = "ENTRY";
                    mCommit = 1'b0;
                end else begin
                    mOpenLeft--;
                    if (mCommit) mOpenLeft = OPEN_CYCLES;
                end
`endif
                if (mCommit) begin
                    if (mKey == 4'hA) begin
                        mMode = "ENTRY";
                    end else if (mKey == 4'hD) begin
                        mEntry.delete();
                        mMode = "SET_NEW";
                    end
                end
            end else if (mMode == "SET_NEW") begin
                if (mCommit) begin
                    if (mKey == 4'hA) begin
                        if (mEntry.size() == CODE_LEN) begin
                            mCode = mEntry;
                            mMode = "ENTRY";
                        end else begin
                            mErr = 1'b1;
                        end
                        mEntry.delete();
                    end else if (mKey == 4'hD) begin
                        mEntry.delete();
                        mMode     = "OPEN";
                        mOpenLeft = OPEN_CYCLES;
                    end else begin
                        modelEdit(mKey);
                    end
                end
            end
        end
    end

    // Cycle-by-cycle comparison of every output against the model
    always @(negedge clk) begin
        if (modelReady) begin
            checkOutput("unlock",    32'(bus.o_unlock),    32'(mMode == "OPEN"));
            checkOutput("alarm",     32'(bus.o_alarm),     32'(mMode == "LOCKOUT"));
            checkOutput("set_mode",  32'(bus.o_set_mode),  32'(mMode == "SET_NEW"));
            checkOutput("err",       32'(bus.o_err),       32'(mErr));
            checkOutput("digit_cnt", 32'(bus.o_digit_cnt), 32'(mEntry.size()));
            checkOutput("entry",     32'(bus.o_entry),     32'(modelEntryWord()));
            checkOutput("fail_cnt",  32'(bus.o_fail_cnt),  32'(mFail));
            if (bus.o_err)   errPulses++;
            if (bus.o_alarm) alarmCycles++;
        end
    end

    // One full key press: strobe low for 4 cycles, then released and settled
    task automatic applyStimulus(input logic [3:0] key);
        @(negedge clk);
        bus.i_key_val  = key;
        bus.i_key_flag = 1'b0;
        repeat (4) @(negedge clk);
        bus.i_key_flag = 1'b1;
        repeat (6) @(negedge clk);
    endtask

    task automatic enterCode(input logic [15:0] code);
        for (int i = 3; i >= 0; i--) applyStimulus(code[4*i +: 4]);
        applyStimulus(4'hA);
    endtask

    task automatic doReset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic finishRun();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    endtask

    // Safety net against a stuck run
    initial begin
        #1000000;
        errors++;
        $display("[TB] FAIL watchdog expired at %0t", $time);
        finishRun();
    end

    // Directed scenario sequence
    initial begin
        int errBase;
        int alarmBase;
        int budget;

        rst            = 1'b1;
        bus.i_key_val  = 4'h0;
        bus.i_key_flag = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        $display("[TB] reset state");
        checkOutput("rst_entry",     32'(bus.o_entry),     32'h0000FFFF);
        checkOutput("rst_digit_cnt", 32'(bus.o_digit_cnt), 32'd0);
        checkOutput("rst_unlock",    32'(bus.o_unlock),    32'd0);

        $display("[TB] correct code");
        enterCode(16'h1234);
        checkOutput("open_unlock", 32'(bus.o_unlock),   32'd1);
        checkOutput("open_fail",   32'(bus.o_fail_cnt), 32'd0);
        applyStimulus(4'hA);
        checkOutput("relock", 32'(bus.o_unlock), 32'd0);

        $display("[TB] edit keys");
        applyStimulus(4'h1); applyStimulus(4'h2); applyStimulus(4'h9);
        applyStimulus(4'hB); applyStimulus(4'h3); applyStimulus(4'h4);
        checkOutput("edit_entry",       32'(bus.o_entry),     32'h00001234);
        checkOutput("model_edit_entry", 32'(modelEntryWord()), 32'h00001234);
        applyStimulus(4'hA);
        checkOutput("edit_unlock", 32'(bus.o_unlock), 32'd1);
        applyStimulus(4'hA);
        for (int i = 0; i < 5; i++) applyStimulus(4'h5);
        checkOutput("sat_cnt",   32'(bus.o_digit_cnt), 32'd4);
        checkOutput("sat_entry", 32'(bus.o_entry),     32'h00005555);
        applyStimulus(4'hC);
        applyStimulus(4'hB);
        checkOutput("clear_back_cnt", 32'(bus.o_digit_cnt), 32'd0);
        checkOutput("clear_entry",    32'(bus.o_entry),     32'h0000FFFF);

        $display("[TB] lockout");
        errBase   = errPulses;
        alarmBase = alarmCycles;
        enterCode(16'h0000);
        enterCode(16'h0000);
        checkOutput("fail_two", 32'(bus.o_fail_cnt), 32'd2);
        enterCode(16'h0000);
        checkOutput("alarm_on", 32'(bus.o_alarm), 32'd1);
        applyStimulus(4'h7);
        bus.i_key_val  = 4'h8;
        bus.i_key_flag = 1'b0;
        budget = 60;
        while (bus.o_alarm && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        checkOutput("alarm_ends", 32'(bus.o_alarm), 32'd0);
        repeat (3) @(negedge clk);
        bus.i_key_flag = 1'b1;
        repeat (6) @(negedge clk);
        checkOutput("err_pulses",   32'(errPulses - errBase),     32'd3);
        checkOutput("alarm_cycles", 32'(alarmCycles - alarmBase), 32'd20);
        checkOutput("post_lock_fail", 32'(bus.o_fail_cnt),  32'd0);
        checkOutput("post_lock_cnt",  32'(bus.o_digit_cnt), 32'd0);

        $display("[TB] change code");
        enterCode(16'h1234);
        applyStimulus(4'hD);
        checkOutput("set_mode_on", 32'(bus.o_set_mode), 32'd1);
        applyStimulus(4'h9); applyStimulus(4'h8); applyStimulus(4'h7); applyStimulus(4'h6);
        checkOutput("new_entry", 32'(bus.o_entry), 32'h00009876);
        applyStimulus(4'hA);
        checkOutput("new_locked", 32'(bus.o_unlock), 32'd0);
        errBase = errPulses;
        enterCode(16'h1234);
        checkOutput("old_code_err",  32'(errPulses - errBase), 32'd1);
        checkOutput("old_code_fail", 32'(bus.o_fail_cnt),     32'd1);
        enterCode(16'h9876);
        checkOutput("new_code_open", 32'(bus.o_unlock), 32'd1);

        $display("[TB] short codes");
        applyStimulus(4'hD);
        applyStimulus(4'h1); applyStimulus(4'h2);
        errBase = errPulses;
        applyStimulus(4'hA);
        checkOutput("short_set_err",  32'(errPulses - errBase), 32'd1);
        checkOutput("short_set_mode", 32'(bus.o_set_mode),     32'd1);
        applyStimulus(4'hD);
        checkOutput("abort_open", 32'(bus.o_unlock), 32'd1);
        applyStimulus(4'hA);
        enterCode(16'h9876);
        checkOutput("code_kept", 32'(bus.o_unlock), 32'd1);
        applyStimulus(4'hA);
        applyStimulus(4'h1); applyStimulus(4'h2); applyStimulus(4'h3);
        applyStimulus(4'hA);
        checkOutput("short_entry_fail", 32'(bus.o_fail_cnt), 32'd1);

        $display("[TB] reset mid SET_NEW");
        enterCode(16'h9876);
        applyStimulus(4'hD);
        applyStimulus(4'h5);
        doReset();
        checkOutput("rst_set_mode", 32'(bus.o_set_mode),  32'd0);
        checkOutput("rst_set_cnt",  32'(bus.o_digit_cnt), 32'd0);
        checkOutput("rst_set_entry", 32'(bus.o_entry),    32'h0000FFFF);
        enterCode(16'h9876);
        checkOutput("restored_fail", 32'(bus.o_unlock), 32'd0);
        enterCode(16'h1234);
        checkOutput("restored_open", 32'(bus.o_unlock), 32'd1);
        applyStimulus(4'hA);

        $display("[TB] reset mid LOCKOUT");
        for (int i = 0; i < 3; i++) enterCode(16'h0000);
        checkOutput("lock_before_rst", 32'(bus.o_alarm), 32'd1);
        doReset();
        checkOutput("rst_lock_alarm", 32'(bus.o_alarm),    32'd0);
        checkOutput("rst_lock_fail",  32'(bus.o_fail_cnt), 32'd0);

        $display("[TB] open timeout behaviour");
        enterCode(16'h1234);
`ifdef AUTO_RELOCK_EN
        repeat (10) @(negedge clk);
        checkOutput("auto_relock", 32'(bus.o_unlock), 32'd0);
`else
        repeat (30) @(negedge clk);
        checkOutput("open_persists", 32'(bus.o_unlock), 32'd1);
`endif
        repeat (2) @(negedge clk);
        finishRun();
    end

endmodule

// File: doc/lock_code_ctrl.md
Name: lock_code_ctrl

Overview:
- Password-entry and verification controller directly downstream of the 4x4 keypad scanner.
- Consumes the scanner's 4-bit key value and active-low key strobe, and assembles digits into an entry buffer.
- Compares the buffer against the stored code; drives unlock, error and lockout status.
- Supports code change while unlocked. Outputs feed the lock actuator and the display driver.

Parameters:
- CODE_LEN, 4: digits per code (1..7).
- DEFAULT_CODE, 16'h1234: code loaded at reset, BCD, MSD in the top nibble; width CODE_LEN*4.
- MAX_FAIL, 3: consecutive failed attempts that trigger lockout (1..7).
- LOCK_CYCLES, 500_000_000: lockout duration in i_clk cycles.
- OPEN_CYCLES, 250_000_000: auto-relock time. Used only with AUTO_RELOCK_EN.

Ports:
- i_clk, in, 1: system clock. Same clock as the keypad scanner.
- i_rst, in, 1: synchronous reset, active-high.
- i_key_val, in, 4: key code from the scanner (0-9 digit, A enter, B backspace, C clear, D change code, E/F ignored).
- i_key_flag, in, 1: scanner strobe. Idle high; low while a debounced key is held.
- o_unlock, out, 1: high while in OPEN.
- o_err, out, 1: one-cycle pulse on a failed check.
- o_alarm, out, 1: high while in LOCKOUT.
- o_set_mode, out, 1: high while in SET_NEW.
- o_digit_cnt, out, 3: digits currently in the entry buffer.
- o_entry, out, CODE_LEN*4: entry buffer for display. Newest digit in the low nibble; unused nibbles are 4'hF.
- o_fail_cnt, out, 3: consecutive failure count.

Behaviour:
- Reset (i_rst high at a clock edge):
  - state = ENTRY; stored code = DEFAULT_CODE.
  - Buffer all 4'hF; digit_cnt = 0; fail_cnt = 0; timer = 0.
  - All outputs 0, except o_entry = all F.
  - Reset mid-operation aborts every state, including LOCKOUT and SET_NEW.
- Key event:
  - i_key_flag passes through a 2-flop synchronizer.
  - An event is armed on the synchronized falling edge.
  - The event commits on the next synchronized rising edge (key release). i_key_val is sampled at that cycle.
  - A rising edge without a prior armed fall is ignored.
  - Commit latency: 3 i_clk cycles after i_key_flag rises.
  - Exactly one action per press.
- ENTRY:
  - Digit with digit_cnt < CODE_LEN: shift the buffer left 4 bits, insert the digit in the low nibble, digit_cnt++.
  - Digit with digit_cnt == CODE_LEN: ignored.
  - B: shift right 4 bits, fill the top nibble with F, digit_cnt--. No-op at digit_cnt 0.
  - C: clear the buffer, digit_cnt = 0.
  - A: go to CHECK. D, E, F: ignored.
- CHECK (1 cycle):
  - Match requires digit_cnt == CODE_LEN and buffer == stored code.
  - On match: fail_cnt = 0, clear the buffer, go to OPEN.
  - On mismatch: pulse o_err, fail_cnt++ (saturates at 7), clear the buffer.
  - After a mismatch: if fail_cnt reaches MAX_FAIL, go to LOCKOUT; otherwise go to ENTRY.
- LOCKOUT:
  - timer counts from 0 and all keys are ignored.
  - At timer == LOCK_CYCLES-1: fail_cnt = 0, timer = 0, go to ENTRY.
  - Keys pressed during lockout are not committed afterwards; a pending armed event is discarded on exit.
- OPEN:
  - A: relock (go to ENTRY).
  - D: go to SET_NEW with the buffer cleared.
  - Other keys are ignored.
- SET_NEW:
  - Digit, B and C handling is identical to ENTRY.
  - A with digit_cnt == CODE_LEN: stored code = buffer, clear the buffer, go to ENTRY (locked).
  - A with digit_cnt < CODE_LEN: pulse o_err, clear the buffer, stay in SET_NEW.
  - D: abort, clear the buffer, return to OPEN. The stored code is unchanged.
- Simultaneous events:
  - A commit in the same cycle as the LOCKOUT or OPEN timer expiry is dropped; the timer transition wins.
  - Reset overrides everything.

Optional Feature:
- Macro name: AUTO_RELOCK_EN.
- Defined:
  - The OPEN timer counts from entry into OPEN.
  - At OPEN_CYCLES-1 the block returns to ENTRY automatically.
  - Any key commit in OPEN restarts the timer before the key is acted on.
- Undefined:
  - OPEN persists until A or D is pressed.
  - No OPEN timer hardware is built and OPEN_CYCLES is unused.

Test Plan:
- Correct code: reset, press 1,2,3,4,A (each as a flag low/high pulse) → o_unlock=1 and o_fail_cnt=0 three cycles after A releases.
- Edit keys: press 1,2,9,B,3,4,A → buffer 0x1234 before A, unlock. Press 5 five times → o_digit_cnt saturates at 4, o_entry=0x5555.
- Lockout (MAX_FAIL=3, LOCK_CYCLES=20): enter 0000+A three times → o_err pulses three times, o_alarm=1 for exactly 20 cycles; keys during alarm have no effect; then o_fail_cnt=0.
- Change code: unlock, D, 9,8,7,6,A → o_unlock=0. Entering 1234+A then fails (o_err); entering 9876+A unlocks. Reset restores 1234.
- Short-code cases: A with digit_cnt=3 in ENTRY counts as a failure. In SET_NEW, A with 2 digits pulses o_err and stays in SET_NEW. D in SET_NEW returns to OPEN with the code unchanged.
- Reset and auto-relock: assert i_rst mid-LOCKOUT and mid-SET_NEW → all outputs return to reset values next cycle. With AUTO_RELOCK_EN and OPEN_CYCLES=10, o_unlock falls after 10 cycles.
